// File: rtl/packet_pkg.sv
// Shared definitions for the byte-stream packet link (transmit framer and receive parsers).
// PACKET_TX_GAP_EN adds the inter-frame GAP state to the state enum.
package packet_pkg;

  localparam logic [7:0]  SOF_DEFAULT = 8'hD5;
  localparam int          HDR_BYTES   = 4;
  localparam int          CRC_BYTES   = 2;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEST,
    ST_SRC,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC_HI,
    ST_CRC_LO
`ifdef PACKET_TX_GAP_EN
    ,
    ST_GAP
`endif
  } pkt_state_e;

endpackage

// File: rtl/crc16_ccitt_update.sv
// One-byte CRC-16-CCITT step (MSB-first, unreflected); combinational.
// Shared by the transmit framer and the receive-side CRC checker.
module crc16_ccitt_update
  import packet_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] w_c;

  always_comb begin
    w_c = i_crc ^ {i_data, 8'h00};
    for (int b = 0; b < 8; b++) begin
      w_c = w_c[15] ? ((w_c << 1) ^ CRC_POLY) : (w_c << 1);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/packet_tx_fsm.sv
// Transmit framer: SOF, DEST, SRC, LEN, payload, CRC-16 hi/lo on a registered byte bus.
// Define PACKET_TX_GAP_EN to insert IFG_CYCLES idle cycles after every packet.
module packet_tx_fsm
  import packet_pkg::*;
#(
  parameter int         PAYLOAD_LEN = 48,
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         IFG_CYCLES  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dest_addr,
  input  logic [7:0] src_addr,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic [7:0] data,
  output logic       control,
  output logic       busy,
  output logic       done
);

  if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > 255 || IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_param_check
    $error("packet_tx_fsm: PAYLOAD_LEN and IFG_CYCLES must lie in 1..255");
  end

  localparam logic [7:0] LEN_BYTE = 8'(PAYLOAD_LEN);
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  pkt_state_e  r_state, w_state_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_control, w_control_nxt;
  logic        r_done, w_done_nxt;
  logic [15:0] r_crc, w_crc_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_dest, w_dest_nxt;
  logic [7:0]  r_src, w_src_nxt;
  logic [15:0] w_crc_upd;

`ifdef PACKET_TX_GAP_EN
  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);
  logic [7:0] r_gap, w_gap_nxt;
`endif

  crc16_ccitt_update u_crc (
    .i_crc  (r_crc),
    .i_data (pl_data),
    .o_crc  (w_crc_upd)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_control_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_crc_nxt     = r_crc;
    w_cnt_nxt     = r_cnt;
    w_dest_nxt    = r_dest;
    w_src_nxt     = r_src;
`ifdef PACKET_TX_GAP_EN
    w_gap_nxt     = r_gap;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_dest_nxt    = dest_addr;
          w_src_nxt     = src_addr;
          w_data_nxt    = SOF_BYTE;
          w_control_nxt = 1'b1;
          w_crc_nxt     = CRC_INIT;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_DEST;
        end
      end
      ST_DEST: begin
        w_data_nxt    = r_dest;
        w_control_nxt = 1'b1;
        w_state_nxt   = ST_SRC;
      end
      ST_SRC: begin
        w_data_nxt    = r_src;
        w_control_nxt = 1'b1;
        w_state_nxt   = ST_LEN;
      end
      ST_LEN: begin
        w_data_nxt    = LEN_BYTE;
        w_control_nxt = 1'b1;
        w_state_nxt   = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        // A cycle without pl_valid is a stall: nothing advances and data holds.
        if (pl_valid) begin
          w_data_nxt    = pl_data;
          w_control_nxt = 1'b1;
          w_crc_nxt     = w_crc_upd;
          w_cnt_nxt     = r_cnt + 8'd1;
          if (r_cnt == LAST_IDX) w_state_nxt = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        w_data_nxt    = r_crc[15:8];
        w_control_nxt = 1'b1;
        w_state_nxt   = ST_CRC_LO;
      end
      ST_CRC_LO: begin
        w_data_nxt    = r_crc[7:0];
        w_control_nxt = 1'b1;
        w_done_nxt    = 1'b1;
`ifdef PACKET_TX_GAP_EN
        w_gap_nxt     = '0;
        w_state_nxt   = ST_GAP;
`else
        w_state_nxt   = ST_IDLE;
`endif
      end
`ifdef PACKET_TX_GAP_EN
      ST_GAP: begin
        if (r_gap == IFG_LAST) w_state_nxt = ST_IDLE;
        else                   w_gap_nxt   = r_gap + 8'd1;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_control <= 1'b0;
      r_done    <= 1'b0;
      r_crc     <= CRC_INIT;
      r_cnt     <= '0;
      r_dest    <= '0;
      r_src     <= '0;
`ifdef PACKET_TX_GAP_EN
      r_gap     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_control <= w_control_nxt;
      r_done    <= w_done_nxt;
      r_crc     <= w_crc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dest    <= w_dest_nxt;
      r_src     <= w_src_nxt;
`ifdef PACKET_TX_GAP_EN
      r_gap     <= w_gap_nxt;
`endif
    end
  end

  assign pl_ready = (r_state == ST_PAYLOAD);
  assign busy     = (r_state != ST_IDLE);
  assign data     = r_data;
  assign control  = r_control;
  assign done     = r_done;

endmodule

// File: doc/packet_tx_fsm.md
Name: packet_tx_fsm

Overview:
- Transmit-side framer for the byte-stream packet link; the counterpart of the receive-side header/payload/CRC parsing FSMs.
- Takes a start request, header fields and a payload stream, and emits one complete packet on an 8-bit data bus qualified by a control strobe. Byte order: SOF, DEST, SRC, LEN, PAYLOAD_LEN payload bytes, CRC-16 high byte, CRC-16 low byte.
- Sits between the packet source (payload buffer) and the link output that feeds the receiver chain.

Parameters:
- PAYLOAD_LEN, 48, payload bytes per packet; legal range 1..255; payload plus CRC is 50 bytes at default.
- SOF_BYTE, 8'hD5, start-of-frame byte value.
- IFG_CYCLES, 4, idle cycles after each packet; used only when PACKET_TX_GAP_EN is defined; legal range 1..255.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send one packet; sampled only in IDLE.
- dest_addr  input  8  destination byte; latched on accepted start.
- src_addr  input  8  source byte; latched on accepted start.
- pl_data  input  8  payload byte.
- pl_valid  input  1  pl_data holds a valid byte.
- pl_ready  output  1  block accepts pl_data this cycle; combinational, high only in PAYLOAD state.
- data  output  8  link byte; registered.
- control  output  1  data valid this cycle; registered; one byte per high cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, coincident with the CRC low byte on data.

Behaviour:
- Reset and clock: reset is synchronous, active-high, named reset; the clock is named clock. Reset has priority over all other inputs.
- Reset values: data=0, control=0, done=0, crc=16'hFFFF, byte counter=0, state=IDLE. busy=0 and pl_ready=0 follow from the IDLE state.
- States: IDLE, DEST, SRC, LEN, PAYLOAD, CRC_HI, CRC_LO, plus GAP when PACKET_TX_GAP_EN is defined.
- IDLE:
  - With start=1 at an edge: latch dest_addr and src_addr, set data<=SOF_BYTE, control<=1, crc<=16'hFFFF, counter<=0, state<=DEST.
  - Otherwise control<=0.
- DEST, SRC, LEN: each edge emits the latched dest, latched src, then PAYLOAD_LEN[7:0]; control<=1; advances to the next state in order, ending in PAYLOAD.
- PAYLOAD:
  - pl_ready=1.
  - At an edge with pl_valid=1: data<=pl_data, control<=1, crc<=crc16_next(crc, pl_data), counter++.
  - At an edge with pl_valid=0: control<=0, data holds its value, no other state changes (stall).
  - After accepting byte number PAYLOAD_LEN (counter==PAYLOAD_LEN-1 at that edge), state<=CRC_HI.
- CRC_HI: data<=crc[15:8], control<=1, state<=CRC_LO.
- CRC_LO: data<=crc[7:0], control<=1, done<=1, state<=IDLE (GAP if PACKET_TX_GAP_EN is defined). done drops on the following cycle.
- CRC arithmetic:
  - CRC-16-CCITT: polynomial 16'h1021, init 16'hFFFF, MSB-first, no reflection, no final XOR.
  - Covers payload bytes only; header and SOF are excluded.
- Latency:
  - start accepted at edge 0 -> SOF visible in the cycle after edge 0.
  - With no payload stalls, control is high for exactly PAYLOAD_LEN+6 consecutive cycles (54 at default).
  - Each stall cycle inserts exactly one control=0 cycle.
- Boundary conditions:
  - start while busy: ignored; no queuing.
  - start held high: back-to-back packets, the next SOF in the cycle after CRC_LO, so done and the next SOF are adjacent.
  - pl_valid outside PAYLOAD: ignored; pl_ready is low there.
  - Counter width: 8 bits; PAYLOAD_LEN=255 must not wrap before CRC_HI.
  - Reset mid-packet: packet abandoned, control=0 from the next cycle, latched fields discarded.

Optional Feature:
- Macro: PACKET_TX_GAP_EN.
- Defined: CRC_LO goes to GAP. GAP holds control=0 and busy=1 for IFG_CYCLES cycles, then returns to IDLE. start is ignored during GAP.
- Undefined: no GAP state; CRC_LO goes straight to IDLE; IFG_CYCLES is unused.

Decomposition:
- Shared package packet_pkg:
  - state enum type;
  - SOF default;
  - HDR_BYTES=4, CRC_BYTES=2;
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF.
- The package is shared with the receive parsers.
- One sub-module: crc16_ccitt_update, a combinational 8-bit-in/16-bit next-CRC block. It is reused by the receive-side CRC checker.

Test Plan:
- Reset, then idle 10 cycles with pl_valid=1 -> control=0, busy=0, pl_ready=0, data=0 throughout.
- PAYLOAD_LEN=9, start with dest=8'h12, src=8'h34, payload ASCII "123456789" streamed without stalls -> bytes D5,12,34,09,31..39,29,B1 on 15 consecutive control cycles; done with the B1 byte.
- Default parameters, pl_valid deasserted on every 3rd payload cycle -> exactly one control=0 gap per stall, still 54 bytes total, CRC matches the reference model.
- Pulse start again at byte 20 of a packet -> ignored; busy stays 1; exactly one packet emitted.
- Assert reset at payload byte 10 -> control=0 on the next cycle; a new start produces a full, correct packet from SOF.
- PACKET_TX_GAP_EN defined, IFG_CYCLES=4, start held high -> exactly 4 control=0 cycles between CRC low byte and the next SOF.
